// File: rtl/frame_write_arbiter.sv
// Shared burst-write engine: grants memory bursts to CH_NUM frame streams.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
`timescale 1ns/1ps
module frame_write_arbiter #(
  parameter int CH_NUM     = 4,
  parameter int ADDR_BITS  = 24,
  parameter int BUSRT_BITS = 10,
  parameter int BURST_SIZE = 128,
  parameter int LEVEL_BITS = 16,
  localparam int SEL_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                         mem_clk,
  input  logic                         rst_n,
  input  logic [CH_NUM-1:0]            frame_start,
  input  logic [CH_NUM*ADDR_BITS-1:0]  frame_base,
  input  logic [CH_NUM*ADDR_BITS-1:0]  frame_len,
  input  logic [CH_NUM*LEVEL_BITS-1:0] fifo_level,
  output logic [CH_NUM-1:0]            fifo_rd_en,
  output logic [SEL_W-1:0]             data_sel,
  output logic [CH_NUM-1:0]            frame_done,
  output logic                         wr_burst_req,
  output logic [BUSRT_BITS-1:0]        wr_burst_len,
  output logic [ADDR_BITS-1:0]         wr_burst_addr,
  input  logic                         wr_burst_data_req,
  input  logic                         wr_burst_finish,
  output logic                         busy
);
  localparam int CW =
    ((ADDR_BITS > LEVEL_BITS) ? ADDR_BITS : LEVEL_BITS) + 1;
  localparam logic [CW-1:0] BS_W = CW'(BURST_SIZE);

  typedef enum logic [1:0] {
    S_IDLE, S_ARB, S_BURST, S_UPDATE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_BITS-1:0]  base_in   [CH_NUM];
  logic [ADDR_BITS-1:0]  len_in    [CH_NUM];
  logic [LEVEL_BITS-1:0] level_q   [CH_NUM];
  logic [ADDR_BITS-1:0]  cur_addr  [CH_NUM];
  logic [ADDR_BITS-1:0]  remain    [CH_NUM];
  logic [ADDR_BITS-1:0]  pend_base [CH_NUM];
  logic [ADDR_BITS-1:0]  pend_len  [CH_NUM];
  logic [BUSRT_BITS-1:0] blen      [CH_NUM];

  logic [CH_NUM-1:0] active;
  logic [CH_NUM-1:0] pend;
  logic [CH_NUM-1:0] elig;
  logic [CH_NUM-1:0] owned;
  logic [SEL_W-1:0]  pick;
  logic              found;

  logic                 restart;
  logic [ADDR_BITS-1:0] new_base;
  logic [ADDR_BITS-1:0] new_len;
  logic [ADDR_BITS-1:0] upd_rem;

`ifndef ARB_FIXED_PRIO_EN
  logic [SEL_W-1:0] rr_q;
  int               idx;
`endif

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      base_in[i] = frame_base[i*ADDR_BITS +: ADDR_BITS];
      len_in[i]  = frame_len[i*ADDR_BITS +: ADDR_BITS];
      if (CW'(remain[i]) >= BS_W) begin
        elig[i] = active[i] & (CW'(level_q[i]) >= BS_W);
        blen[i] = BUSRT_BITS'(BURST_SIZE);
      end else begin
        elig[i] = active[i] &
                  (CW'(level_q[i]) >= CW'(remain[i]));
        blen[i] = BUSRT_BITS'(remain[i]);
      end
    end
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick  = SEL_W'(i);
        found = 1'b1;
      end
    end
`else
    idx = 0;
    for (int k = 1; k <= CH_NUM; k++) begin
      idx = (int'(rr_q) + k) % CH_NUM;
      if (!found && elig[idx]) begin
        pick  = SEL_W'(idx);
        found = 1'b1;
      end
    end
`endif
  end

  // A channel is owned from the cycle it wins ARB until UPDATE retires it
  always_comb begin
    owned = '0;
    if (state_q == S_ARB && found)
      owned[pick] = 1'b1;
    if (state_q == S_BURST || state_q == S_UPDATE)
      owned[data_sel] = 1'b1;
  end

  always_comb begin
    restart  = frame_start[data_sel] | pend[data_sel];
    new_base = frame_start[data_sel] ? base_in[data_sel]
                                     : pend_base[data_sel];
    new_len  = frame_start[data_sel] ? len_in[data_sel]
                                     : pend_len[data_sel];
    upd_rem  = remain[data_sel] - ADDR_BITS'(wr_burst_len);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (|active) state_d = S_ARB;
      S_ARB: begin
        if (found)        state_d = S_BURST;
        else if (!(|active)) state_d = S_IDLE;
      end
      S_BURST:  if (wr_burst_finish) state_d = S_UPDATE;
      S_UPDATE: state_d = S_ARB;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sel      <= '0;
      wr_burst_req  <= 1'b0;
      wr_burst_len  <= '0;
      wr_burst_addr <= '0;
    end else begin
      if (state_q == S_ARB && found) begin
        data_sel      <= pick;
        wr_burst_addr <= cur_addr[pick];
        wr_burst_len  <= blen[pick];
        wr_burst_req  <= 1'b1;
      end
      if (state_q == S_BURST && wr_burst_finish)
        wr_burst_req <= 1'b0;
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n)
      rr_q <= SEL_W'(CH_NUM - 1);
    else if (state_q == S_UPDATE)
      rr_q <= data_sel;
  end
`endif

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= '0;
      pend       <= '0;
      frame_done <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        level_q[i]   <= '0;
        cur_addr[i]  <= '0;
        remain[i]    <= '0;
        pend_base[i] <= '0;
        pend_len[i]  <= '0;
      end
    end else begin
      frame_done <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        level_q[i] <= fifo_level[i*LEVEL_BITS +: LEVEL_BITS];
        if (frame_start[i]) begin
          if (owned[i]) begin
            pend[i]      <= 1'b1;
            pend_base[i] <= base_in[i];
            pend_len[i]  <= len_in[i];
          end else begin
            cur_addr[i]   <= base_in[i];
            remain[i]     <= len_in[i];
            active[i]     <= (len_in[i] != '0);
            frame_done[i] <= (len_in[i] == '0);
          end
        end
      end
      // A restart discards the frame in flight without signalling done
      if (state_q == S_UPDATE) begin
        if (restart) begin
          pend[data_sel]       <= 1'b0;
          cur_addr[data_sel]   <= new_base;
          remain[data_sel]     <= new_len;
          active[data_sel]     <= (new_len != '0);
          frame_done[data_sel] <= (new_len == '0);
        end else begin
          cur_addr[data_sel] <=
            cur_addr[data_sel] + ADDR_BITS'(wr_burst_len);
          remain[data_sel] <= upd_rem;
          if (upd_rem == '0) begin
            active[data_sel]     <= 1'b0;
            frame_done[data_sel] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    fifo_rd_en = '0;
    if (state_q == S_BURST)
      fifo_rd_en[data_sel] = wr_burst_data_req;
  end

  assign busy = (state_q != S_IDLE) | (|active);

endmodule

// File: doc/frame_write_arbiter.md
Name: frame_write_arbiter

Overview:
Multi-channel burst-write scheduler for the external memory controller write port. It replaces per-stream write FSMs with one shared engine. Up to CH_NUM frame streams each buffer pixels in their own write FIFO outside this block. The arbiter watches FIFO fill levels, grants bursts round-robin, tracks each channel's frame address and remaining length, and pulses a per-channel frame-done strobe.

Parameters:
CH_NUM, 4, number of write channels (1..8)
ADDR_BITS, 24, memory word address width
BUSRT_BITS, 10, burst length port width
BURST_SIZE, 128, maximum burst length in memory words (must be < 2**BUSRT_BITS)
LEVEL_BITS, 16, FIFO read-side level width per channel

Ports:
mem_clk  in  1  memory controller user clock; the only clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  CH_NUM  per-channel one-cycle pulse: begin new frame
frame_base  in  CH_NUM*ADDR_BITS  per-channel frame base address, sampled on frame_start
frame_len  in  CH_NUM*ADDR_BITS  per-channel frame length in memory words, sampled on frame_start
fifo_level  in  CH_NUM*LEVEL_BITS  per-channel FIFO read-side used words
fifo_rd_en  out  CH_NUM  one-hot FIFO read enable = wr_burst_data_req routed to granted channel
data_sel  out  clog2(CH_NUM)  granted channel index, drives external write-data mux
frame_done  out  CH_NUM  one-cycle pulse when channel's frame fully written
wr_burst_req  out  1  burst write request to memory controller
wr_burst_len  out  BUSRT_BITS  burst length in words
wr_burst_addr  out  ADDR_BITS  burst base address
wr_burst_data_req  in  1  controller data request
wr_burst_finish  in  1  controller burst complete
busy  out  1  high whenever any channel is active or FSM not IDLE

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM IDLE; all channels inactive; rr pointer = CH_NUM-1, so channel 0 has first priority.
- Per-channel registers: active, cur_addr, remain (ADDR_BITS), pending-start flag with latched base/len.
- frame_start[i] on a channel not currently granted: next cycle cur_addr=base, remain=len, active=1. If len==0: active stays 0; frame_done[i] pulses the next cycle.
- frame_start[i] while channel i is granted: base/len latched as pending and applied in UPDATE after the current burst. The current frame is abandoned, with no frame_done for it.
- Eligible[i] = active & (remain >= BURST_SIZE ? level >= BURST_SIZE : level >= remain).
- FSM states:
  - IDLE: go to ARB when any channel is active.
  - ARB: when any channel is eligible, grant the first eligible channel after the rr pointer (cyclic). Register grant, data_sel, wr_burst_addr=cur_addr, wr_burst_len=min(remain,BURST_SIZE). Go to BURST. If no channel is eligible, stay in ARB, or return to IDLE when no channel is active.
  - BURST: wr_burst_req=1, held until wr_burst_finish is seen, then cleared on the following edge. fifo_rd_en[grant] = wr_burst_data_req combinationally; other bits 0. Go to UPDATE.
  - UPDATE (1 cycle): cur_addr += burst_len (wraps mod 2**ADDR_BITS); remain -= burst_len; rr pointer = grant. If remain hits 0: active=0, frame_done[grant] pulses. Apply any pending start. Go to ARB.
- Arbitration latency: eligible to wr_burst_req = 2 cycles (ARB registers, BURST asserts).
- wr_burst_addr, wr_burst_len and data_sel are stable from ARB exit through UPDATE.
- wr_burst_finish outside BURST is ignored. wr_burst_data_req outside BURST produces no fifo_rd_en.
- frame_done pulses for several channels may coincide (zero-length starts plus UPDATE).

Optional Feature:
ARB_FIXED_PRIO_EN: when defined, ARB grants the lowest-index eligible channel and the rr pointer is unused. When undefined, round-robin as above.

Test Plan:
- Reset mid-BURST (rst_n low 1 cycle while wr_burst_req=1) -> next edge all outputs 0, busy=0, FSM IDLE.
- Ch0 start base=0x1000 len=300, level held 512 -> bursts addr 0x1000/len128, 0x1080/128, 0x1100/44; frame_done[0] one pulse after third wr_burst_finish.
- Ch0 and ch2 both eligible, long frames -> grants alternate 0,2,0,2; with ARB_FIXED_PRIO_EN only ch0 until its frame completes.
- Ch1 len=100, level=99 -> no request; level rises to 100 -> wr_burst_req 2 cycles later, len=100.
- frame_start[3] len=0 -> frame_done[3] next cycle, no burst issued.
- frame_start[0] base=0x8000 during ch0 burst -> burst completes unchanged; next ch0 burst addr=0x8000, no frame_done for abandoned frame.
